// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte channel between NUM_REQ
// packet producers. Ownership is held for a whole packet (until the byte
// flagged last is accepted) and is forcibly released when the owner stays
// idle for LOCK_TIMEOUT cycles mid-packet.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic                 tx_wvalid_o,
  input  logic                 tx_wready_i,
  output logic [7:0]           tx_wdata_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_TIMEOUT);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q;
  logic [PTR_W-1:0]   owner_q;
  logic [PTR_W-1:0]   rr_q;
  logic [PTR_W-1:0]   rr_next;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_vld;
  logic [CNT_W-1:0]   cnt_q;
  logic               timeout_q;
  logic               own_valid;
  logic               own_last;
  logic               xfer;
  logic               done;
  logic               expire;

  // A completing transfer always wins over an expiring idle counter.
  assign xfer    = tx_wvalid_o && tx_wready_i;
  assign done    = xfer && own_last;
  assign expire  = (state_q == S_GRANT) && (cnt_q == CNT_MAX) && !xfer;
  assign rr_next = (owner_q == LAST_IDX) ? '0 : owner_q + PTR_W'(1);

  // Round-robin pick: first valid requester at or above rr, else first from 0.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_vld && req_valid_i[k] && (k >= int'(rr_q))) begin
        pick_vld = 1'b1;
        pick_idx = PTR_W'(k);
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_vld && req_valid_i[k]) begin
        pick_vld = 1'b1;
        pick_idx = PTR_W'(k);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: IDLE grants on any request, GRANT leaves on completion or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick_vld)        state_d = S_GRANT;
      S_GRANT: if (done || expire)  state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // Grant, owner index, rr pointer, idle counter and timeout pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_q   <= '0;
      owner_q   <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (pick_vld) begin
            grant_q <= NUM_REQ'(1) << pick_idx;
            owner_q <= pick_idx;
          end
        end
        S_GRANT: begin
          if (done || expire) begin
            grant_q <= '0;
            rr_q    <= rr_next;
            cnt_q   <= '0;
          end else if (xfer) begin
            cnt_q <= '0;
          end else if (!own_valid) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: the owner's byte stream is muxed combinationally from the registered grant.
  always_comb begin
    own_valid  = 1'b0;
    own_last   = 1'b0;
    tx_wdata_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        own_valid  = req_valid_i[k];
        own_last   = req_last_i[k];
        tx_wdata_o = req_data_i[8*k +: 8];
      end
    end
    busy_o      = (state_q == S_GRANT);
    tx_wvalid_o = busy_o && own_valid;
    req_ready_o = busy_o ? (grant_q & {NUM_REQ{tx_wready_i}}) : '0;
    grant_o     = grant_q;
    timeout_o   = timeout_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packets are queued per requester, the expected
// byte stream (requester, data, last) is pushed in service order as stimulus
// is issued, and a monitor pops and compares on every uart_tx transfer.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int LT = 16;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic [N-1:0]   req_valid_i;
  logic [N-1:0]   req_ready_o;
  logic [8*N-1:0] req_data_i;
  logic [N-1:0]   req_last_i;
  logic           tx_wvalid_o;
  logic           tx_wready_i;
  logic [7:0]     tx_wdata_o;
  logic [N-1:0]   grant_o;
  logic           busy_o;
  logic           timeout_o;

  typedef struct {
    int         req;
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] pq[N][$];
  int         hold_cnt[N];
  int         pause_after[N];
  logic       started[N];
  int         gseq[$];
  int         eorder[$];
  int         cyc;
  int         errors;
  int         checks;
  int         rdy_mode;
  int         mdl_rr;
  bit         gap_en;

  uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(LT)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .tx_wvalid_o (tx_wvalid_o),
    .tx_wready_i (tx_wready_i),
    .tx_wdata_o  (tx_wdata_o),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int oh2idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < N; k++) s += pq[k].size();
    return s;
  endfunction

  task automatic add_byte(input int k, input logic [7:0] d, input logic last);
    exp_t e;
    pq[k].push_back({last, d});
    e.req = k; e.data = d; e.last = last;
    exp_q.push_back(e);
  endtask

  // Present each requester's head byte and the uart_tx ready pattern.
  task automatic drive();
    logic [8:0] e;
    logic       v;
    for (int k = 0; k < N; k++) begin
      e = 9'h0;
      v = 1'b0;
      if (pq[k].size() > 0) begin
        e = pq[k][0];
        v = (hold_cnt[k] == 0) && !(gap_en && started[k] && ($urandom_range(0, 3) == 0));
      end
      req_valid_i[k]         = v;
      req_last_i[k]          = e[8];
      req_data_i[8*k +: 8]   = e[7:0];
    end
    case (rdy_mode)
      0:       tx_wready_i = 1'b0;
      1:       tx_wready_i = 1'b1;
      2:       tx_wready_i = 1'($urandom_range(0, 1));
      default: tx_wready_i = (cyc % 10 == 0);
    endcase
  endtask

  // One clock: sample handshakes mid-cycle, then update requesters after the edge.
  task automatic tick();
    logic [N-1:0] acc;
    logic [8:0]   ent;
    @(negedge clk_i);
    acc = req_valid_i & req_ready_o;
    @(posedge clk_i);
    #1;
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (hold_cnt[k] > 0) hold_cnt[k]--;
      if (acc[k] && pq[k].size() > 0) begin
        ent = pq[k].pop_front();
        started[k] = !ent[8];
        if (pause_after[k] > 0) begin
          hold_cnt[k]    = pause_after[k];
          pause_after[k] = 0;
        end
      end
    end
    drive();
  endtask

  task automatic run_drain(input string nm, input int bound);
    int           n = 0;
    logic [N-1:0] prev = '0;
    gseq.delete();
    while (pending() > 0 && n < bound) begin
      tick();
      n++;
      if (grant_o != '0 && grant_o != prev) gseq.push_back(oh2idx(grant_o));
      prev = grant_o;
    end
    chk({nm, "_drained"}, pending(), 0);
  endtask

  task automatic check_order(input string nm);
    chk({nm, "_len"}, gseq.size(), eorder.size());
    for (int i = 0; i < eorder.size() && i < gseq.size(); i++) chk(nm, gseq[i], eorder[i]);
  endtask

  // Monitor: protocol invariants every cycle, scoreboard compare on every transfer.
  initial begin
    exp_t e;
    int   g;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        chk("grant_onehot0", int'($onehot0(grant_o)), 1);
        chk("ready_non_owner", int'(req_ready_o & ~grant_o), 0);
        if (tx_wvalid_o && tx_wready_i) begin
          g = oh2idx(grant_o);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte: got req %0d data 0x%0h, required none", g, tx_wdata_o);
          end else begin
            e = exp_q.pop_front();
            if (g != e.req || tx_wdata_o !== e.data || req_last_i[g] !== e.last) begin
              errors++;
              $display("FAIL byte_stream: got req %0d data 0x%0h last %0b, required req %0d data 0x%0h last %0b",
                       g, tx_wdata_o, req_last_i[g], e.req, e.data, e.last);
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, tx_cyc, c_first, c_last, last_k, mask, len, k;
    bit tmo;
    errors = 0; checks = 0; cyc = 0; rdy_mode = 1; gap_en = 0; mdl_rr = 0;
    for (int i = 0; i < N; i++) begin
      hold_cnt[i] = 0; pause_after[i] = 0; started[i] = 1'b0;
    end

    // Reset with busy-looking inputs: outputs must stay quiet.
    req_valid_i = '1; req_last_i = '1; req_data_i = 32'hA5C3_5A3C; tx_wready_i = 1'b1;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_grant", int'(grant_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_timeout", int'(timeout_o), 0);
    chk("rst_wvalid", int'(tx_wvalid_o), 0);
    chk("rst_wdata", int'(tx_wdata_o), 0);
    chk("rst_ready", int'(req_ready_o), 0);
    rst_i = 1'b0;
    drive();
    tick();

    // Contention from rr=0: all four 2-byte packets, served 0,1,2,3.
    rdy_mode = 2;
    for (int r = 0; r < N; r++) begin
      add_byte(r, 8'($urandom), 1'b0);
      add_byte(r, 8'($urandom), 1'b1);
    end
    eorder = '{0, 1, 2, 3};
    drive();
    run_drain("contention", 300);
    check_order("contention_order");

    // Wrap-around: after 3 completes, 0 comes before 3.
    add_byte(3, 8'h31, 1'b0); add_byte(3, 8'h32, 1'b1);
    add_byte(0, 8'h01, 1'b0); add_byte(0, 8'h02, 1'b1);
    // Scoreboard order must be service order: 0's bytes before 3's.
    exp_q.delete();
    add_byte(0, 8'h01, 1'b0); add_byte(0, 8'h02, 1'b1);
    add_byte(3, 8'h31, 1'b0); add_byte(3, 8'h32, 1'b1);
    void'(pq[0].pop_back()); void'(pq[0].pop_back());
    void'(pq[3].pop_back()); void'(pq[3].pop_back());
    eorder = '{0, 3};
    drive();
    run_drain("wrap", 100);
    check_order("wrap_order");

    // Single packet from req 2 with uart ready once every 10 cycles.
    rdy_mode = 3;
    add_byte(2, 8'h41, 1'b0); add_byte(2, 8'h42, 1'b0); add_byte(2, 8'h43, 1'b1);
    drive();
    tick();
    chk("single_grant", int'(grant_o), 4);
    chk("single_wvalid", int'(tx_wvalid_o), 1);
    n = 0;
    while (pq[2].size() > 0 && n < 100) begin
      tick();
      n++;
      if (pq[2].size() > 0) chk("single_hold_grant", int'(grant_o), 4);
    end
    chk("single_drained", pq[2].size(), 0);
    chk("single_release", int'(grant_o), 0);
    chk("single_busy_off", int'(busy_o), 0);

    // Timeout: req 1 stalls after one non-last byte, req 2 is waiting.
    rdy_mode = 1;
    add_byte(1, 8'h11, 1'b0);
    add_byte(2, 8'h21, 1'b0); add_byte(2, 8'h22, 1'b1);
    drive();
    n = 0;
    while (pq[1].size() > 0 && n < 10) begin tick(); n++; end
    chk("timeout_first_byte", pq[1].size(), 0);
    tx_cyc = cyc;
    n = 0;
    while (!timeout_o && n < 40) begin tick(); n++; end
    chk("timeout_latency", cyc - tx_cyc, LT + 1);
    chk("timeout_grant_drop", int'(grant_o), 0);
    tick();
    chk("timeout_pulse_width", int'(timeout_o), 0);
    chk("timeout_next_grant", int'(grant_o), 4);
    started[1] = 1'b0;
    run_drain("timeout", 100);

    // Stalled uart with valid high is not a timeout.
    rdy_mode = 0;
    add_byte(0, 8'h5A, 1'b1);
    drive();
    tmo = 0;
    for (int i = 0; i < 105; i++) begin tick(); if (timeout_o) tmo = 1; end
    chk("stall_no_timeout", int'(tmo), 0);
    chk("stall_grant_kept", int'(grant_o), 1);
    rdy_mode = 1;
    drive();
    run_drain("stall", 20);

    // Last byte accepted in the very cycle the idle counter hits the limit.
    pause_after[1] = LT;
    add_byte(1, 8'hC1, 1'b0); add_byte(1, 8'hC2, 1'b1);
    drive();
    tmo = 0; n = 0; c_first = -1;
    while (pq[1].size() > 0 && n < 60) begin
      tick();
      n++;
      if (timeout_o) tmo = 1;
      if (pq[1].size() == 1 && c_first < 0) c_first = cyc;
    end
    c_last = cyc;
    chk("collide_spacing", c_last - c_first, LT + 1);
    chk("collide_release", int'(grant_o), 0);
    for (int i = 0; i < 3; i++) begin tick(); if (timeout_o) tmo = 1; end
    chk("collide_no_timeout", int'(tmo), 0);

    // Asynchronous reset in the middle of req 0's packet.
    rdy_mode = 3;
    for (int i = 0; i < 4; i++) add_byte(0, 8'(8'h70 + i), 1'(i == 3));
    drive();
    n = 0;
    while (grant_o != 4'b0001 && n < 10) begin tick(); n++; end
    repeat (12) tick();
    chk("areset_pre_grant", int'(grant_o), 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("areset_grant", int'(grant_o), 0);
    chk("areset_wvalid", int'(tx_wvalid_o), 0);
    chk("areset_busy", int'(busy_o), 0);
    chk("areset_ready", int'(req_ready_o), 0);
    pq[0].delete();
    exp_q.delete();
    started[0] = 1'b0;
    drive();
    tick();
    tick();
    rst_i = 1'b0;
    rdy_mode = 1;
    add_byte(1, 8'hB1, 1'b0); add_byte(1, 8'hB2, 1'b1);
    drive();
    tick();
    chk("areset_new_grant", int'(grant_o), 2);
    run_drain("areset", 20);
    mdl_rr = 2;

    // Random rounds: random subsets, lengths, bytes, valid gaps and uart readiness.
    gap_en = 1;
    rdy_mode = 2;
    for (int r = 0; r < 30; r++) begin
      mask = $urandom_range(1, (1 << N) - 1);
      eorder.delete();
      last_k = mdl_rr;
      for (int i = 0; i < N; i++) begin
        k = (mdl_rr + i) % N;
        if (mask[k]) begin
          len = $urandom_range(1, 5);
          for (int b = 0; b < len; b++) add_byte(k, 8'($urandom), 1'(b == len - 1));
          eorder.push_back(k);
          last_k = k;
        end
      end
      drive();
      run_drain("random", 600);
      check_order("random_order");
      mdl_rr = (last_k + 1) % N;
    end

    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
